// File: rtl/rr_grant_pkg.sv
// Shared definitions for the round-robin grant sequencer: state encoding,
// sizing constants and the rotating first-one search used by the arbiter.
package rr_grant_pkg;

   localparam int STATE_W = 2;
   // Widest requester vector the search helper handles.
   localparam int MAX_N   = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      LAST  = 2'd2
   } state_t;

   // Returns a one-hot vector marking the first asserted request found when
   // scanning ptr+1, ptr+2, ... modulo n. ptr itself is visited last, so the
   // previous owner has the lowest priority. All-zero when nothing requests.
   function automatic logic [MAX_N-1:0] rr_first_onehot(
      input logic [MAX_N-1:0] req,
      input logic [2:0]       ptr,
      input int               n
   );
      logic [MAX_N-1:0] oh;
      logic             found;
      logic [2:0]       idx;
      oh    = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_N; k++) begin
         if (k <= n && !found) begin
            idx = 3'((4'(ptr) + 4'(k)) % 4'(n));
            if (req[idx]) begin
               oh[idx] = 1'b1;
               found   = 1'b1;
            end
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: chooses the next owner after ptr.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    win,
   output logic             valid
);
   import rr_grant_pkg::*;

   logic [MAX_N-1:0] req_pad;
   logic [MAX_N-1:0] win_onehot;

   // Widen the request vector to the helper's fixed width; unused lanes idle.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_N; gi++) begin : g_pad
         if (gi < N_REQ) begin : g_on
            assign req_pad[gi] = req[gi];
         end else begin : g_off
            assign req_pad[gi] = 1'b0;
         end
      end
   endgenerate

   // Rotating first-one search starting just after the last owner.
   always_comb begin
      win_onehot = rr_first_onehot(req_pad, 3'(ptr), N_REQ);
   end

   // One-hot to index encode of the winner.
   always_comb begin
      win = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (win_onehot[i]) win = IW'(i);
      end
   end

   assign valid = |win_onehot;

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin owner sequencer for a single shared resource. One owner holds
// gnt until it drops its request or MAX_HOLD cycles elapse; each tenure is
// bracketed by start/done strobes. All outputs are registered and decoded
// from the next state so they move on the same edge as the state.
module rr_grant_fsm #(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 16,
   localparam int IW       = $clog2(N_REQ),
   localparam int CW       = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    owner,
   output logic             busy,
   output logic             start,
   output logic             done,
   output logic             timeout
);
   import rr_grant_pkg::*;

   localparam logic [CW-1:0]    HOLD_LAST = CW'(MAX_HOLD - 1);
   localparam logic [N_REQ-1:0] GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

   state_t           state_reg;
   state_t           state_next;
   logic [IW-1:0]    ptr_reg;
   logic [IW-1:0]    owner_reg;
   logic [CW-1:0]    hold_cnt_reg;
   logic [N_REQ-1:0] gnt_reg;
   logic             busy_reg;
   logic             start_reg;
   logic             done_reg;
   logic             timeout_reg;

   logic [IW-1:0]    pick_win;
   logic             pick_valid;
   logic             owner_req;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .win   (pick_win),
      .valid (pick_valid)
   );

   assign owner_req = req[owner_reg];

   // Next-state decode; an owner releases on its own or when its hold budget runs out.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pick_valid) state_next = GRANT;
         GRANT:   if (!owner_req || hold_cnt_reg == HOLD_LAST) state_next = LAST;
         LAST:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, pointer, hold counter and registered outputs decoded from state_next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= IW'(N_REQ - 1);
         owner_reg    <= '0;
         hold_cnt_reg <= '0;
         gnt_reg      <= '0;
         busy_reg     <= 1'b0;
         start_reg    <= 1'b0;
         done_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= '0;
         start_reg   <= 1'b0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         busy_reg    <= (state_next != IDLE);

         // The pointer moves to the finished owner so it is scanned last next time.
         if (state_reg == LAST) ptr_reg <= owner_reg;

         case (state_next)
            GRANT: begin
               if (state_reg == IDLE) begin
                  owner_reg    <= pick_win;
                  gnt_reg      <= GNT_ONE << pick_win;
                  start_reg    <= 1'b1;
                  hold_cnt_reg <= '0;
               end else begin
                  gnt_reg      <= GNT_ONE << owner_reg;
                  hold_cnt_reg <= hold_cnt_reg + CW'(1);
               end
            end
            LAST: begin
               done_reg    <= 1'b1;
               timeout_reg <= owner_req;
            end
            default: ;
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign owner   = owner_reg;
   assign busy    = busy_reg;
   assign start   = start_reg;
   assign done    = done_reg;
   assign timeout = timeout_reg;

`ifndef SYNTHESIS
   string state_name;
   // Readable state label for waveform and log inspection.
   always_comb begin
      case (state_reg)
         IDLE:    state_name = "IDLE";
         GRANT:   state_name = "GRANT";
         LAST:    state_name = "LAST";
         default: state_name = "XXX";
      endcase
   end
`endif

endmodule

// File: doc/rr_grant_fsm.md
Name: rr_grant_fsm

Overview:
- Round-robin arbiter and sequencer that shares one single-owner resource between N_REQ requesters.
- Built in the same dff-onState FSM style as the block's neighbours: registered outputs are decoded from nextstate, so outputs change on the same edge the state does.
- Sits between the requesting engines and the shared resource. Issues a one-hot grant plus start/done/timeout strobes.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold gnt; legal range 2..256.
- IW, $clog2(N_REQ), width of the owner index (derived; not overridden).
- CW, $clog2(MAX_HOLD), width of the hold counter (derived; not overridden).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N_REQ  per-requester level request; held until served.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- owner  output  IW  index of the current or last granted requester, registered.
- busy  output  1  high while the FSM is outside IDLE, registered.
- start  output  1  one-cycle pulse on the first gnt cycle of each tenure.
- done  output  1  one-cycle pulse on the release cycle (first cycle gnt is low again).
- timeout  output  1  one-cycle pulse, coincident with done, when release was forced by MAX_HOLD.

Behaviour:
- Reset values, applied at the rst_n-low edge:
  - state=IDLE, gnt=0, owner=0, busy=0, start=0, done=0, timeout=0.
  - rr pointer ptr=N_REQ-1, so req[0] has first priority after reset.
  - hold_cnt=0.
- Reset asserted mid-tenure: gnt drops at that edge. No done or timeout pulse is generated.
- States and transitions:
  - IDLE: if |req, nextstate=GRANT and win=rr_pick(req, ptr); otherwise stay in IDLE.
  - GRANT: go to LAST when !req[owner], or when hold_cnt==MAX_HOLD-1. Otherwise stay in GRANT and increment hold_cnt.
  - LAST: one cycle, gnt=0; ptr<=owner; nextstate=IDLE unconditionally.
  - Illegal encoding: nextstate=IDLE.
- Arbitration: winner is the first asserted req searching ptr+1, ptr+2, ... modulo N_REQ. ptr itself is checked last.
- Owner is captured only on the IDLE->GRANT transition. Changes on req[other] during GRANT are ignored.
- Registered outputs, computed from nextstate and assigned default 0 each cycle:
  - gnt[win] = (nextstate==GRANT).
  - start = (state==IDLE && nextstate==GRANT).
  - done = (nextstate==LAST).
  - timeout = (nextstate==LAST && req[owner] still high).
  - busy = (nextstate!=IDLE).
- Latency:
  - req rises before edge k; gnt is high after edge k (one-cycle request-to-grant).
  - Minimum gap between two tenures is 2 gnt-low cycles (LAST, IDLE).
- Hold counter:
  - Cleared on entering GRANT.
  - gnt is high for at most MAX_HOLD cycles.
  - Never wraps; saturation is prevented by the forced transition to LAST.
- Boundary cases:
  - Owner drops req on its first gnt cycle: tenure is 1 cycle; start and done fall on adjacent cycles.
  - Timed-out owner still requesting: it re-enters arbitration with the lowest priority.
  - Only one requester active: it is re-granted after the 2-cycle gap.
  - All req simultaneous after reset: grant order is 0,1,2,3,0,...
- Simulation-only state_name decode (IDLE/GRANT/LAST/XXX), guarded by ifndef SYNTHESIS.

Decomposition:
- Shared package rr_grant_pkg:
  - State encoding: IDLE=2'd0, GRANT=2'd1, LAST=2'd2.
  - State width constant.
  - Helper function for the rotating first-one search.
- One sub-module, rr_pick: combinational, parameterised by N_REQ. Takes req and ptr; returns win index and a valid bit.
- FSM, counter and output registers stay in rr_grant_fsm.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> gnt=0, busy=0, no strobes.
- req=4'b1111 held constant, MAX_HOLD=16 -> tenures go to owners 0,1,2,3,0 in that order. Each gnt is high exactly 16 cycles with timeout=1 at each release. Exactly 2 gnt-low cycles separate tenures.
- req[2] pulsed for 1 cycle from IDLE -> gnt=4'b0100 for 1 cycle, start then done on consecutive cycles, timeout=0, ptr becomes 2.
- Owner 1 granted; req[3] rises mid-tenure; req[1] drops after 5 gnt cycles -> gnt[1] high for 5 cycles, then owner=3 granted 2 cycles after done. req[3] has no effect during tenure 1.
- rst_n driven low on the 7th gnt cycle of a tenure -> gnt=0 and busy=0 at that edge, no done pulse. After release of rst_n with req=4'b0011, owner 0 is granted first.
- Single requester req=4'b1000 held 40 cycles -> repeated 16-cycle tenures to owner 3, each ending in timeout, with a 2-cycle gap between them.
